// File: rtl/button_event_pkg.sv
//------------------------------------------------------------------------------
// Module : button_event_pkg
// Purpose: Shared definitions for the button event classifier. Holds the FSM
//          state type, the smallest legal tick parameters, and a small helper
//          that sizes the shared cycle counter.
// Ports  : none (package)
// Config : BUTTON_EVENT_DOUBLE_CLICK_EN (consumed by button_event_fsm)
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package button_event_pkg;

  // All five states are always declared so that both builds share one
  // encoding. The single-click-only build never enters the last two.
  typedef enum logic [2:0] {
    ST_IDLE           = 3'd0,
    ST_PRESSED        = 3'd1,
    ST_LONG_HELD      = 3'd2,
    ST_WAIT_SECOND    = 3'd3,
    ST_SECOND_PRESSED = 3'd4
  } button_event_state_t;

  // Smallest legal values of the timing parameters. A terminal count of
  // TICKS-1 must be reachable after the entry cycle, which needs TICKS >= 2.
  localparam int unsigned LONG_TICKS_MIN   = 2;
  localparam int unsigned DOUBLE_TICKS_MIN = 2;

  function automatic int unsigned max_ticks(input int unsigned a,
                                            input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage : button_event_pkg

`default_nettype wire

// File: rtl/edge_detector.sv
//------------------------------------------------------------------------------
// Module : edge_detector
// Purpose: Flags rising and falling edges of a level that is already
//          synchronous to clk, by comparing it with a one-cycle-delayed copy.
// Ports  : clk  - system clock, rising edge
//          rst  - asynchronous active-low reset (delayed copy clears to 0)
//          in   - level to watch
//          rise - combinational, high while in=1 and the delayed copy is 0
//          fall - combinational, high while in=0 and the delayed copy is 1
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module edge_detector (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise,
  output logic fall
);

  logic in_q;

  // Clearing the delayed copy to 0 makes a level that is already high when
  // reset releases look like a fresh rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_q <= 1'b0;
    end else begin
      in_q <= in;
    end
  end

  assign rise = in & ~in_q;
  assign fall = ~in & in_q;

endmodule : edge_detector

`default_nettype wire

// File: rtl/button_event_fsm.sv
//------------------------------------------------------------------------------
// Module : button_event_fsm
// Purpose: Classifies a debounced button level into press / release / click /
//          double-click / long-press events. Every output is a registered
//          one-cycle pulse, visible the cycle after the clock edge at which
//          the event was recognised.
// Ports  : clk          - system clock, rising edge
//          rst          - asynchronous active-low reset
//          btn          - debounced button level, synchronous to clk
//          press        - pulse on each btn rising edge
//          release_o    - pulse on each btn falling edge ("release" is a
//                         reserved word in SystemVerilog, hence the suffix)
//          click        - pulse for a completed single short press
//          double_click - pulse for two short presses within the window
//          long_press   - pulse when a hold reaches LONG_TICKS
// Params : LONG_TICKS   - cycles a press must be held to count as long (>=2)
//          DOUBLE_TICKS - window after a short release for a second press
//                         (>=2); unused for behaviour without the macro below
// Config : BUTTON_EVENT_DOUBLE_CLICK_EN - when defined, double-click detection
//          is built in. When undefined, a short release reports click at once
//          and double_click is held at 0.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module button_event_fsm
  import button_event_pkg::*;
#(
  parameter int unsigned LONG_TICKS   = 12_000_000,
  parameter int unsigned DOUBLE_TICKS = 3_600_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press,
  output logic release_o,
  output logic click,
  output logic double_click,
  output logic long_press
);

  // One counter serves both the long-press and double-click timeouts, so it
  // is sized for the larger of the two.
  localparam int unsigned CNT_W = $clog2(max_ticks(LONG_TICKS, DOUBLE_TICKS) + 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic rise;
  logic fall;

  edge_detector u_edge_detector (
    .clk  (clk),
    .rst  (rst),
    .in   (btn),
    .rise (rise),
    .fall (fall)
  );

  button_event_state_t state_q, state_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic                press_q,   press_d;
  logic                release_q, release_d;
  logic                click_q,   click_d;
  logic                long_q,    long_d;

`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
  localparam logic [CNT_W-1:0] DOUBLE_LAST = CNT_W'(DOUBLE_TICKS - 1);

  logic double_q, double_d;
`endif

  // Next-state logic. The counter is cleared on every state change and only
  // counts in PRESSED and WAIT_SECOND; each terminal count forces an exit,
  // so it never wraps.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    click_d   = 1'b0;
    long_d    = 1'b0;
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
    double_d  = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          press_d = 1'b1;
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end
      end

      ST_PRESSED: begin
        // A release on the very cycle the hold would become long still
        // counts as short, so the falling edge is tested first.
        if (fall) begin
          release_d = 1'b1;
          cnt_d     = '0;
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
          state_d   = ST_WAIT_SECOND;
`else
          click_d   = 1'b1;
          state_d   = ST_IDLE;
`endif
        end else if (btn && (cnt_q == LONG_LAST)) begin
          long_d  = 1'b1;
          state_d = ST_LONG_HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_LONG_HELD: begin
        // Ending a long hold never yields a click.
        if (fall) begin
          release_d = 1'b1;
          state_d   = ST_IDLE;
          cnt_d     = '0;
        end
      end

`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
      ST_WAIT_SECOND: begin
        // A second press arriving on the timeout cycle beats the click.
        if (rise) begin
          press_d = 1'b1;
          state_d = ST_SECOND_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DOUBLE_LAST) begin
          click_d = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_SECOND_PRESSED: begin
        // The length of the second press is irrelevant; no long detection.
        if (fall) begin
          release_d = 1'b1;
          double_d  = 1'b1;
          state_d   = ST_IDLE;
          cnt_d     = '0;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      click_q   <= click_d;
      long_q    <= long_d;
    end
  end

`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      double_q <= 1'b0;
    end else begin
      double_q <= double_d;
    end
  end

  assign double_click = double_q;
`else
  assign double_click = 1'b0;
`endif

  assign press      = press_q;
  assign release_o  = release_q;
  assign click      = click_q;
  assign long_press = long_q;

endmodule : button_event_fsm

`default_nettype wire

// File: tb/tb_button_event_fsm.sv
//------------------------------------------------------------------------------
// Module : tb_button_event_fsm
// Purpose: Self-checking bench for button_event_fsm with LONG_TICKS=20 and
//          DOUBLE_TICKS=10. Expectations follow BUTTON_EVENT_DOUBLE_CLICK_EN
//          as seen by this file.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_button_event_fsm;

  localparam int L = 20;
  localparam int D = 10;
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
  localparam bit DBL_EN = 1'b1;
`else
  localparam bit DBL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn = 1'b0;
  logic press, release_o, click, double_click, long_press;
  wire [4:0] outs;
  assign outs = {press, release_o, click, double_click, long_press};

  always #5 clk = ~clk;

  button_event_fsm #(
    .LONG_TICKS   (L),
    .DOUBLE_TICKS (D)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn          (btn),
    .press        (press),
    .release_o    (release_o),
    .click        (click),
    .double_click (double_click),
    .long_press   (long_press)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: works from absolute edge times rather than states.
  int t;          // index of sampled clock edges since start
  bit pb;         // btn level at previous edge (0 after reset)
  bit pending;    // a short release is waiting for its click / second press
  int rel_t;      // edge index of that short release
  bit second;     // current hold is the second press of a double click
  bit long_done;  // current hold already reported long (or ended)
  int rise_t;     // edge index of the current hold's rising edge

  function automatic void model_reset();
    pb = 1'b0; pending = 1'b0; second = 1'b0; long_done = 1'b0;
    rise_t = 0; rel_t = 0;
  endfunction

  // Returns {press, release, click, double_click, long_press} for this edge.
  function automatic logic [4:0] model_step(input logic b);
    bit r, f;
    logic c, dc, lp;
    r = b && !pb;
    f = !b && pb;
    c = 1'b0; dc = 1'b0; lp = 1'b0;
    if (r) begin
      second    = DBL_EN && pending && ((t - rel_t) <= D);
      pending   = 1'b0;
      rise_t    = t;
      long_done = 1'b0;
    end
    if (f) begin
      if (second) begin
        dc = 1'b1;
        second = 1'b0;
      end else if (!long_done) begin
        if (DBL_EN) begin
          pending = 1'b1;
          rel_t   = t;
        end else begin
          c = 1'b1;
        end
      end
      long_done = 1'b1;
    end
    // Held for L edges after the rise without falling: long.
    if (b && !r && !second && !long_done && ((t - rise_t) == L)) begin
      lp = 1'b1;
      long_done = 1'b1;
    end
    // D edges after a short release with no new press: click.
    if (pending && !r && ((t - rel_t) == D)) begin
      c = 1'b1;
      pending = 1'b0;
    end
    pb = b;
    t++;
    return {r, f, c, dc, lp};
  endfunction

  // Event bookkeeping for the scenario checks.
  int cyc = 0;
  int n_press, n_rel, n_click, n_dbl, n_long;
  int press_cyc, rel_cyc, click_cyc, dbl_cyc, long_cyc;

  task automatic clear_counts();
    n_press = 0; n_rel = 0; n_click = 0; n_dbl = 0; n_long = 0;
    press_cyc = -1; rel_cyc = -1; click_cyc = -1; dbl_cyc = -1; long_cyc = -1;
  endtask

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual={p,r,c,d,l}=%b required=%b", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Called at a negedge: drive btn, take one rising edge, compare at +1.
  task automatic step(input logic b, input bit use_tbl, input logic [4:0] tbl_exp,
                      input string name);
    logic [4:0] e;
    btn = b;
    @(posedge clk);
    if (rst) begin
      e = model_step(b);
    end else begin
      model_reset();
      e = 5'b0;
    end
    if (use_tbl) e = tbl_exp;
    #1;
    check(name, outs, e);
    if (outs[4]) begin n_press++; press_cyc = cyc; end
    if (outs[3]) begin n_rel++;   rel_cyc   = cyc; end
    if (outs[2]) begin n_click++; click_cyc = cyc; end
    if (outs[1]) begin n_dbl++;   dbl_cyc   = cyc; end
    if (outs[0]) begin n_long++;  long_cyc  = cyc; end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input logic b, input int n, input string name);
    for (int i = 0; i < n; i++) step(b, 1'b0, 5'b0, name);
  endtask

  // Asserts reset between clock edges, checks the outputs clear at once,
  // holds it for `hold` further cycles with random btn, then releases it.
  task automatic async_reset(input int hold, input string name);
    #1 rst = 1'b0;
    #1 check(name, outs, 5'b0);
    model_reset();
    @(negedge clk);
    for (int i = 0; i < hold; i++) step(1'($urandom_range(0, 1)), 1'b0, 5'b0, name);
    btn = 1'b0;
    rst = 1'b1;
  endtask

  typedef struct {
    logic       rst;
    logic       btn;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic [4:0] rel_exp;
    rel_exp = {1'b0, 1'b1, ~DBL_EN, 1'b0, 1'b0};
    // Reset held with btn toggling, then basic press/release and a reset
    // taken while a click may be pending, then btn high across reset release.
    tbl[0]  = '{1'b0, 1'b1, 5'b00000};
    tbl[1]  = '{1'b0, 1'b0, 5'b00000};
    tbl[2]  = '{1'b0, 1'b1, 5'b00000};
    tbl[3]  = '{1'b1, 1'b0, 5'b00000};
    tbl[4]  = '{1'b1, 1'b1, 5'b10000};
    tbl[5]  = '{1'b1, 1'b1, 5'b00000};
    tbl[6]  = '{1'b1, 1'b0, rel_exp};
    tbl[7]  = '{1'b1, 1'b0, 5'b00000};
    tbl[8]  = '{1'b0, 1'b1, 5'b00000};
    tbl[9]  = '{1'b1, 1'b1, 5'b10000};
    tbl[10] = '{1'b1, 1'b0, rel_exp};

    t = 0;
    model_reset();
    clear_counts();
    rst = 1'b0;
    btn = 1'b0;
    @(negedge clk);
    #1 check("reset_state", outs, 5'b0);
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      rst = tbl[i].rst;
      step(tbl[i].btn, 1'b1, tbl[i].exp, $sformatf("table[%0d]", i));
    end
    run(1'b0, 25, "settle");

    // Single click.
    clear_counts();
    run(1'b1, 5, "single_hi");
    run(1'b0, 15, "single_lo");
    check_int("single_press_cnt", n_press, 1);
    check_int("single_rel_cnt", n_rel, 1);
    check_int("single_click_cnt", n_click, 1);
    check_int("single_click_delay", click_cyc - rel_cyc, DBL_EN ? D : 0);
    check_int("single_no_dbl_long", n_dbl + n_long, 0);

    // Double click.
    clear_counts();
    run(1'b1, 3, "dbl_hi1");
    run(1'b0, 4, "dbl_lo1");
    run(1'b1, 3, "dbl_hi2");
    run(1'b0, 15, "dbl_lo2");
    check_int("dbl_press_cnt", n_press, 2);
    check_int("dbl_rel_cnt", n_rel, 2);
    check_int("dbl_dbl_cnt", n_dbl, DBL_EN ? 1 : 0);
    check_int("dbl_click_cnt", n_click, DBL_EN ? 0 : 2);
    if (DBL_EN) check_int("dbl_with_release", dbl_cyc, rel_cyc);

    // Long press.
    clear_counts();
    run(1'b1, 30, "long_hi");
    run(1'b0, 15, "long_lo");
    check_int("long_cnt", n_long, 1);
    check_int("long_delay", long_cyc - press_cyc, L);
    check_int("long_rel_cnt", n_rel, 1);
    check_int("long_no_click_dbl", n_click + n_dbl, 0);

    // Release on the exact long boundary is short.
    clear_counts();
    run(1'b1, L, "edge_long_hi");
    run(1'b0, 15, "edge_long_lo");
    check_int("edge_long_none", n_long, 0);
    check_int("edge_long_click", n_click, 1);

    // Second press on the last window cycle wins over the click.
    clear_counts();
    run(1'b1, 2, "edge_win_hi1");
    run(1'b0, D, "edge_win_lo1");
    run(1'b1, 2, "edge_win_hi2");
    run(1'b0, 15, "edge_win_lo2");
    check_int("edge_win_dbl", n_dbl, DBL_EN ? 1 : 0);
    check_int("edge_win_click", n_click, DBL_EN ? 0 : 2);

    // Reset during the double-click window.
    run(1'b1, 3, "mid_hi");
    run(1'b0, 1, "mid_lo");
    async_reset(2, "mid_rst");
    clear_counts();
    run(1'b0, 20, "mid_after");
    check_int("mid_no_click", n_click + n_dbl + n_long, 0);

    // Random bursts against the model, with occasional resets.
    for (int i = 0; i < 220; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        async_reset($urandom_range(1, 2), "rand_rst");
      end else begin
        run(1'($urandom_range(0, 1)), $urandom_range(1, 25), "random");
      end
    end
    run(1'b0, 25, "final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_button_event_fsm

`default_nettype wire
